// File: rtl/grid_pkg.sv
// Shared playfield definitions: cell width, cell encodings and the default
// values the clear sweep and out-of-range reads produce.
package grid_pkg;

    localparam int unsigned CELL_W = 2;

    typedef enum logic [CELL_W-1:0] {
        CELL_EMPTY = 2'd0,
        CELL_BODY  = 2'd1,
        CELL_FOOD  = 2'd2,
        CELL_WALL  = 2'd3
    } cell_t;

    // Out-of-range cells read as wall so the game logic needs no bounds check.
    localparam logic [CELL_W-1:0] OOB_VAL_DEF   = CELL_WALL;
    localparam logic [CELL_W-1:0] CLEAR_VAL_DEF = CELL_EMPTY;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/grid_ram_ctrl_if.sv
// Game/display-facing bus of the playfield store; master is the client side,
// slave is the controller.
interface grid_ram_ctrl_if
    import grid_pkg::*;
#(
    parameter int unsigned DATA_W = CELL_W,
    parameter int unsigned X_W    = 3,
    parameter int unsigned Y_W    = 3
);
    logic              clr_req;
    logic              busy;
    logic              wr_en;
    logic [X_W-1:0]    wr_x;
    logic [Y_W-1:0]    wr_y;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              wr_err;
    logic              disp_rd_en;
    logic [X_W-1:0]    disp_x;
    logic [Y_W-1:0]    disp_y;
    logic [DATA_W-1:0] disp_rd_data;
    logic              disp_rd_valid;
    logic              gp_rd_req;
    logic [X_W-1:0]    gp_x;
    logic [Y_W-1:0]    gp_y;
    logic              gp_rd_pend;
    logic [DATA_W-1:0] gp_rd_data;
    logic              gp_rd_valid;

    modport master (
        output clr_req, wr_en, wr_x, wr_y, wr_data,
               disp_rd_en, disp_x, disp_y, gp_rd_req, gp_x, gp_y,
        input  busy, wr_ack, wr_err, disp_rd_data, disp_rd_valid,
               gp_rd_pend, gp_rd_data, gp_rd_valid
    );

    modport slave (
        input  clr_req, wr_en, wr_x, wr_y, wr_data,
               disp_rd_en, disp_x, disp_y, gp_rd_req, gp_x, gp_y,
        output busy, wr_ack, wr_err, disp_rd_data, disp_rd_valid,
               gp_rd_pend, gp_rd_data, gp_rd_valid
    );

endinterface

// File: rtl/grid_ram_1r1w.sv
// Simple dual-port RAM: synchronous write, registered read, no array reset,
// so it maps onto a single block RAM.
module grid_ram_1r1w
    import grid_pkg::*;
#(
    parameter int unsigned DATA_W = CELL_W,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/grid_ram_ctrl.sv
// Playfield store: coordinate mapping, clear sweep, display/game read-port
// arbitration (display first) and write-to-read forwarding around one 1R1W RAM.
module grid_ram_ctrl
    import grid_pkg::*;
#(
    parameter int unsigned       DATA_W    = CELL_W,
    parameter int unsigned       GRID_W    = 8,
    parameter int unsigned       GRID_H    = 8,
    parameter int unsigned       X_W       = 3,
    parameter int unsigned       Y_W       = 3,
    parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(CLEAR_VAL_DEF),
    parameter logic [DATA_W-1:0] OOB_VAL   = DATA_W'(OOB_VAL_DEF)
) (
    input logic             clk,
    input logic             rst_n,
    grid_ram_ctrl_if.slave  bus
);

    localparam int unsigned DEPTH  = GRID_W * GRID_H;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t LAST_ADDR = ADDR_W'(DEPTH - 1);

    function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (32'(x) < 32'(GRID_W)) && (32'(y) < 32'(GRID_H));
    endfunction

    function automatic addr_t to_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return ADDR_W'(32'(y) * 32'(GRID_W) + 32'(x));
    endfunction

    ctrl_state_t state_q, state_d;
    addr_t       cnt_q, cnt_d;
    logic        busy;

    logic  ram_we, ram_re;
    addr_t ram_waddr, ram_raddr;
    data_t ram_wdata, ram_rdata;

    logic  wr_in, disp_in, gp_in;
    addr_t wr_addr, disp_addr, gp_addr_q;
    logic  wr_ok, wr_bad;
    logic  wr_ack_q, wr_err_q;

    logic  gp_pend_q, gp_pend_d, gp_accept;

    // Per reader: valid, "data comes from RAM" flag, and the non-RAM value
    // (OOB, clear value or forwarded write data).
    logic  disp_vld_d, disp_ram_d, disp_vld_q, disp_ram_q;
    data_t disp_alt_d, disp_alt_q, disp_hold_q, disp_out;
    logic  gp_vld_d, gp_ram_d, gp_vld_q, gp_ram_q;
    data_t gp_alt_d, gp_alt_q, gp_hold_q, gp_out;

    assign busy      = (state_q == ST_CLEAR);
    assign wr_in     = in_range(bus.wr_x, bus.wr_y);
    assign wr_addr   = to_addr(bus.wr_x, bus.wr_y);
    assign disp_in   = in_range(bus.disp_x, bus.disp_y);
    assign disp_addr = to_addr(bus.disp_x, bus.disp_y);
    assign gp_in     = in_range(bus.gp_x, bus.gp_y);
    assign gp_accept = bus.gp_rd_req && !gp_pend_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ram_we     = 1'b0;
        ram_waddr  = cnt_q;
        ram_wdata  = CLEAR_VAL;
        ram_re     = 1'b0;
        ram_raddr  = disp_addr;
        wr_ok      = 1'b0;
        wr_bad     = 1'b0;
        disp_vld_d = bus.disp_rd_en;
        disp_ram_d = 1'b0;
        disp_alt_d = disp_alt_q;
        gp_pend_d  = gp_pend_q;
        gp_vld_d   = 1'b0;
        gp_ram_d   = 1'b0;
        gp_alt_d   = gp_alt_q;

        unique case (state_q)
            ST_CLEAR: begin
                ram_we = 1'b1;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        if (bus.wr_en) begin
            if (!busy && wr_in) begin
                wr_ok     = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = wr_addr;
                ram_wdata = bus.wr_data;
            end else begin
                wr_bad = 1'b1;
            end
        end

        // Display owns the read port whenever it strobes, even for OOB reads.
        if (bus.disp_rd_en) begin
            if (!disp_in) begin
                disp_alt_d = OOB_VAL;
            end else if (busy) begin
                disp_alt_d = CLEAR_VAL;
            end else if (ram_we && ram_waddr == disp_addr) begin
                disp_alt_d = ram_wdata;
            end else begin
                ram_re     = 1'b1;
                ram_raddr  = disp_addr;
                disp_ram_d = 1'b1;
            end
        end else if (gp_pend_q && !busy) begin
            gp_pend_d = 1'b0;
            gp_vld_d  = 1'b1;
            if (ram_we && ram_waddr == gp_addr_q) begin
                gp_alt_d = ram_wdata;
            end else begin
                ram_re    = 1'b1;
                ram_raddr = gp_addr_q;
                gp_ram_d  = 1'b1;
            end
        end

        // Accept never coincides with issue: accept needs pend low, issue needs it high.
        if (gp_accept) begin
            if (gp_in) begin
                gp_pend_d = 1'b1;
            end else begin
                gp_vld_d = 1'b1;
                gp_ram_d = 1'b0;
                gp_alt_d = OOB_VAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            gp_pend_q   <= 1'b0;
            gp_addr_q   <= '0;
            disp_vld_q  <= 1'b0;
            disp_ram_q  <= 1'b0;
            disp_alt_q  <= '0;
            disp_hold_q <= '0;
            gp_vld_q    <= 1'b0;
            gp_ram_q    <= 1'b0;
            gp_alt_q    <= '0;
            gp_hold_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ack_q   <= wr_ok;
            wr_err_q   <= wr_bad;
            gp_pend_q  <= gp_pend_d;
            if (gp_accept && gp_in) begin
                gp_addr_q <= to_addr(bus.gp_x, bus.gp_y);
            end
            disp_vld_q <= disp_vld_d;
            disp_ram_q <= disp_ram_d;
            disp_alt_q <= disp_alt_d;
            if (disp_vld_q) begin
                disp_hold_q <= disp_out;
            end
            gp_vld_q   <= gp_vld_d;
            gp_ram_q   <= gp_ram_d;
            gp_alt_q   <= gp_alt_d;
            if (gp_vld_q) begin
                gp_hold_q <= gp_out;
            end
        end
    end

    // RAM data is only live the cycle after a read; the hold registers keep it.
    assign disp_out = disp_vld_q ? (disp_ram_q ? ram_rdata : disp_alt_q) : disp_hold_q;
    assign gp_out   = gp_vld_q   ? (gp_ram_q   ? ram_rdata : gp_alt_q)   : gp_hold_q;

    grid_ram_1r1w #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign bus.busy          = busy;
    assign bus.wr_ack        = wr_ack_q;
    assign bus.wr_err        = wr_err_q;
    assign bus.disp_rd_data  = disp_out;
    assign bus.disp_rd_valid = disp_vld_q;
    assign bus.gp_rd_pend    = gp_pend_q;
    assign bus.gp_rd_data    = gp_out;
    assign bus.gp_rd_valid   = gp_vld_q;

endmodule

// File: tb/tb_grid_ram_ctrl.sv
// Bench for grid_ram_ctrl: an 8x8 grid with 4-bit coordinates so that
// out-of-range positions can be driven, checked against a cell-level model.
module tb_grid_ram_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    grid_ram_ctrl_if #(.DATA_W(2), .X_W(4), .Y_W(4)) bus ();

    grid_ram_ctrl #(
        .DATA_W    (2),
        .GRID_W    (8),
        .GRID_H    (8),
        .X_W       (4),
        .Y_W       (4),
        .CLEAR_VAL (2'b00),
        .OOB_VAL   (2'b11)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the grid as an 8x8 array of cells, sweep as cycles remaining.
    logic       m_init = 1'b0;
    int         m_clear_left = 0;
    logic [1:0] m_mem [8][8];
    logic       m_pend = 1'b0;
    logic [3:0] m_gx, m_gy;
    logic       e_ack, e_err, e_dvld, e_gvld;
    logic [1:0] e_ddata, e_gdata;

    function automatic logic inr(input logic [3:0] x, input logic [3:0] y);
        return (x < 4'd8) && (y < 4'd8);
    endfunction

    function automatic logic m_wr_ok();
        return bus.wr_en && (m_clear_left == 0) && inr(bus.wr_x, bus.wr_y);
    endfunction

    // A read sees a write accepted in the same cycle to the same cell.
    function automatic logic [1:0] cell_now(input logic [3:0] x, input logic [3:0] y);
        if (m_wr_ok() && x == bus.wr_x && y == bus.wr_y) return bus.wr_data;
        return m_mem[x[2:0]][y[2:0]];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init       <= 1'b1;
            m_clear_left <= 64;
            m_pend       <= 1'b0;
            e_ack        <= 1'b0;
            e_err        <= 1'b0;
            e_dvld       <= 1'b0;
            e_ddata      <= 2'b00;
            e_gvld       <= 1'b0;
            e_gdata      <= 2'b00;
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    m_mem[i][j] <= 2'b00;
        end else if (m_init) begin
            e_ack <= m_wr_ok();
            e_err <= bus.wr_en && !m_wr_ok();
            if (m_wr_ok()) m_mem[bus.wr_x[2:0]][bus.wr_y[2:0]] <= bus.wr_data;
            e_dvld <= bus.disp_rd_en;
            if (bus.disp_rd_en)
                e_ddata <= !inr(bus.disp_x, bus.disp_y) ? 2'b11 :
                           (m_clear_left != 0) ? 2'b00 : cell_now(bus.disp_x, bus.disp_y);
            e_gvld <= 1'b0;
            if (m_pend && !bus.disp_rd_en && m_clear_left == 0) begin
                e_gvld  <= 1'b1;
                e_gdata <= cell_now(m_gx, m_gy);
                m_pend  <= 1'b0;
            end else if (bus.gp_rd_req && !m_pend) begin
                if (!inr(bus.gp_x, bus.gp_y)) begin
                    e_gvld  <= 1'b1;
                    e_gdata <= 2'b11;
                end else begin
                    m_pend <= 1'b1;
                    m_gx   <= bus.gp_x;
                    m_gy   <= bus.gp_y;
                end
            end
            if (m_clear_left != 0) begin
                m_clear_left <= m_clear_left - 1;
            end else if (bus.clr_req) begin
                m_clear_left <= 64;
                for (int i = 0; i < 8; i++)
                    for (int j = 0; j < 8; j++)
                        m_mem[i][j] <= 2'b00;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("busy",          32'(bus.busy),          32'(m_clear_left != 0));
            check("wr_ack",        32'(bus.wr_ack),        32'(e_ack));
            check("wr_err",        32'(bus.wr_err),        32'(e_err));
            check("disp_rd_valid", 32'(bus.disp_rd_valid), 32'(e_dvld));
            check("disp_rd_data",  32'(bus.disp_rd_data),  32'(e_ddata));
            check("gp_rd_pend",    32'(bus.gp_rd_pend),    32'(m_pend));
            check("gp_rd_valid",   32'(bus.gp_rd_valid),   32'(e_gvld));
            check("gp_rd_data",    32'(bus.gp_rd_data),    32'(e_gdata));
        end
    end

    task automatic count_busy(input string name);
        int n = 0;
        while (bus.busy && n < 200) begin
            n++;
            tick();
        end
        check(name, 32'(n), 64);
    endtask

    task automatic scan_zero(input string name);
        for (int i = 0; i < 64; i++) begin
            bus.disp_rd_en = 1'b1;
            bus.disp_x     = 4'(i % 8);
            bus.disp_y     = 4'(i / 8);
            tick();
            check({name, "_vld"},  32'(bus.disp_rd_valid), 1);
            check({name, "_data"}, 32'(bus.disp_rd_data),  0);
        end
        bus.disp_rd_en = 1'b0;
        tick();
        check({name, "_vld_off"}, 32'(bus.disp_rd_valid), 0);
    endtask

    task automatic disp_read(input logic [3:0] x, input logic [3:0] y, input string name,
                             input logic [1:0] exp);
        bus.disp_rd_en = 1'b1;
        bus.disp_x     = x;
        bus.disp_y     = y;
        tick();
        bus.disp_rd_en = 1'b0;
        check({name, "_vld"},  32'(bus.disp_rd_valid), 1);
        check({name, "_data"}, 32'(bus.disp_rd_data),  32'(exp));
    endtask

    task automatic write_cell(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_x    = x;
        bus.wr_y    = y;
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.clr_req = 1'b0; bus.wr_en = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;
        bus.disp_rd_en = 1'b0; bus.disp_x = '0; bus.disp_y = '0;
        bus.gp_rd_req = 1'b0; bus.gp_x = '0; bus.gp_y = '0;
        repeat (3) tick();
        check("rst_busy",   32'(bus.busy),          1);
        check("rst_ack",    32'(bus.wr_ack),        0);
        check("rst_dvld",   32'(bus.disp_rd_valid), 0);
        check("rst_pend",   32'(bus.gp_rd_pend),    0);
        check("rst_gdata",  32'(bus.gp_rd_data),    0);
        rst_n = 1'b1;
        count_busy("busy_after_reset");
        scan_zero("scan0");

        // Write (3,2), read it back through both readers.
        write_cell(4'd3, 4'd2, 2'b10);
        check("w32_ack", 32'(bus.wr_ack), 1);
        check("w32_err", 32'(bus.wr_err), 0);
        tick();
        check("w32_ack_pulse", 32'(bus.wr_ack), 0);
        disp_read(4'd3, 4'd2, "d32", 2'b10);
        bus.gp_rd_req = 1'b1; bus.gp_x = 4'd3; bus.gp_y = 4'd2;
        tick();
        bus.gp_rd_req = 1'b0;
        check("g32_pend_n1", 32'(bus.gp_rd_pend),  1);
        check("g32_vld_n1",  32'(bus.gp_rd_valid), 0);
        tick();
        check("g32_vld_n2",  32'(bus.gp_rd_valid), 1);
        check("g32_data",    32'(bus.gp_rd_data),  2);
        check("g32_pend_n2", 32'(bus.gp_rd_pend),  0);

        // Out-of-range writes are dropped; (8,0) must not alias (0,1), (0,8) not (0,0).
        write_cell(4'd8, 4'd0, 2'b11);
        check("w80_err", 32'(bus.wr_err), 1);
        check("w80_ack", 32'(bus.wr_ack), 0);
        write_cell(4'd0, 4'd8, 2'b01);
        check("w08_err", 32'(bus.wr_err), 1);
        disp_read(4'd0, 4'd1, "d01", 2'b00);
        disp_read(4'd0, 4'd0, "d00", 2'b00);

        // OOB game read answers next cycle even with the display on the port.
        bus.disp_rd_en = 1'b1; bus.disp_x = 4'd0; bus.disp_y = 4'd0;
        bus.gp_rd_req = 1'b1; bus.gp_x = 4'd9; bus.gp_y = 4'd1;
        tick();
        bus.gp_rd_req = 1'b0; bus.disp_rd_en = 1'b0;
        check("g91_vld",  32'(bus.gp_rd_valid), 1);
        check("g91_data", 32'(bus.gp_rd_data),  3);
        check("g91_pend", 32'(bus.gp_rd_pend),  0);
        tick();

        // Game read starved by 10 display cycles; a second request is ignored.
        write_cell(4'd1, 4'd1, 2'b10);
        for (int k = 0; k < 10; k++) begin
            bus.disp_rd_en = 1'b1;
            bus.disp_x = 4'd2; bus.disp_y = 4'd2;
            bus.gp_rd_req = (k == 0 || k == 3);
            bus.gp_x = (k == 0) ? 4'd1 : 4'd2;
            bus.gp_y = (k == 0) ? 4'd1 : 4'd2;
            tick();
            check("starve_pend", 32'(bus.gp_rd_pend),  1);
            check("starve_vld",  32'(bus.gp_rd_valid), 0);
        end
        bus.disp_rd_en = 1'b0; bus.gp_rd_req = 1'b0;
        tick();
        check("starve_done_vld",  32'(bus.gp_rd_valid), 1);
        check("starve_done_data", 32'(bus.gp_rd_data),  2);
        check("starve_done_pend", 32'(bus.gp_rd_pend),  0);
        tick();
        check("starve_after_vld",  32'(bus.gp_rd_valid), 0);
        check("starve_after_pend", 32'(bus.gp_rd_pend),  0);

        // Same-cycle write and display read of (5,5).
        bus.disp_rd_en = 1'b1; bus.disp_x = 4'd5; bus.disp_y = 4'd5;
        write_cell(4'd5, 4'd5, 2'b01);
        bus.disp_rd_en = 1'b0;
        check("fwd55_data", 32'(bus.disp_rd_data), 1);
        check("fwd55_ack",  32'(bus.wr_ack),       1);
        tick();
        check("fwd55_hold", 32'(bus.disp_rd_data), 1);

        // Clear on request; mid-sweep write errors and clr_req does not extend.
        write_cell(4'd0, 4'd0, 2'b01);
        write_cell(4'd7, 4'd7, 2'b11);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        begin
            int n = 0;
            while (bus.busy && n < 200) begin
                n++;
                if (n == 11) check("sweep_wr_err", 32'(bus.wr_err), 1);
                bus.wr_en = (n == 10);
                bus.wr_x = 4'd2; bus.wr_y = 4'd2; bus.wr_data = 2'b10;
                bus.clr_req = (n == 20);
                tick();
            end
            bus.wr_en = 1'b0; bus.clr_req = 1'b0;
            check("busy_after_clr", 32'(n), 64);
        end
        disp_read(4'd0, 4'd0, "clr00", 2'b00);
        disp_read(4'd7, 4'd7, "clr77", 2'b00);
        disp_read(4'd2, 4'd2, "clr22", 2'b00);

        // Reset at sweep cycle 30 restarts a full sweep.
        write_cell(4'd4, 4'd4, 2'b10);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int n = 0; n < 30; n++) tick();
        check("mid_sweep_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_busy("busy_after_mid_reset");
        scan_zero("scan1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
